// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with make/break tracking.
//
// Samples the asynchronous PS/2 clock/data lines, frames 11-bit packets
// (start, 8 data LSB first, parity, stop), and tracks the currently held key
// for a seven-segment display path.
//
// Build option: define PS2_PARITY_CHECK_EN to reject frames with even parity.
// Without it the parity bit is shifted in and ignored.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   clrn       in   asynchronous active-low reset
//   ps2_clk    in   PS/2 clock line (asynchronous)
//   ps2_data   in   PS/2 data line (asynchronous)
//   rx_byte    out  last correctly framed byte (includes F0/E0)
//   rx_valid   out  one-cycle pulse when rx_byte updates
//   frame_err  out  one-cycle pulse on a rejected frame
//   scan_code  out  make code of the currently or last held key
//   blank_flag out  1 = no key held
//   key_count  out  distinct key presses, modulo 256
module ps2_kbd_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [7:0] scan_code,
  output logic       blank_flag,
  output logic [7:0] key_count
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRecv  = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;

  localparam logic [7:0] CodeBreak = 8'hF0;
  localparam logic [7:0] CodeExt   = 8'hE0;

  logic [2:0]     ps2_clk_sync_q, ps2_data_sync_q;
  logic [1:0]     state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [9:0]     shift_q, shift_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           break_pending_q, break_pending_d;
  logic [7:0]     rx_byte_q, rx_byte_d;
  logic           rx_valid_q, rx_valid_d;
  logic           frame_err_q, frame_err_d;
  logic [7:0]     scan_code_q, scan_code_d;
  logic           blank_q, blank_d;
  logic [7:0]     key_count_q, key_count_d;

  logic       ps2_fall;
  logic       data_s;
  logic       parity_ok;
  logic       frame_ok;
  logic [7:0] frame_byte;

  assign ps2_fall = (ps2_clk_sync_q[2:1] == 2'b10);
  // Data taken from the same synchronizer stage as the newer clock sample.
  assign data_s   = ps2_data_sync_q[1];

  // After 10 shifts into the MSB: [7:0] data, [8] parity, [9] stop.
  assign frame_byte = shift_q[7:0];

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^shift_q[8:0];
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_ok = shift_q[9] & parity_ok;

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    to_cnt_d        = to_cnt_q;
    break_pending_d = break_pending_q;
    rx_byte_d       = rx_byte_q;
    rx_valid_d      = 1'b0;
    frame_err_d     = 1'b0;
    scan_code_d     = scan_code_q;
    blank_d         = blank_q;
    key_count_d     = key_count_q;

    case (state_q)
      StIdle: begin
        // A falling edge with data high is not a start bit; stay idle.
        if (ps2_fall && !data_s) begin
          state_d   = StRecv;
          bit_cnt_d = 4'd0;
          to_cnt_d  = '0;
        end
      end

      StRecv: begin
        if (ps2_fall) begin
          shift_d  = {data_s, shift_q[9:1]};
          to_cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = StCheck;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (to_cnt_q == ToLast) begin
          // Abandon the partial frame without flagging an error.
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StCheck: begin
        state_d = StIdle;
        if (frame_ok) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = frame_byte;
          if (frame_byte == CodeBreak) begin
            break_pending_d = 1'b1;
          end else if (frame_byte == CodeExt) begin
            // Extended prefix carries no key state of its own.
            break_pending_d = break_pending_q;
          end else if (break_pending_q) begin
            break_pending_d = 1'b0;
            if (frame_byte == scan_code_q) begin
              blank_d = 1'b1;
            end
          end else if (blank_q) begin
            scan_code_d = frame_byte;
            blank_d     = 1'b0;
            key_count_d = key_count_q + 8'd1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_clk_sync_q  <= 3'b111;
      ps2_data_sync_q <= 3'b111;
      state_q         <= StIdle;
      bit_cnt_q       <= 4'd0;
      shift_q         <= 10'd0;
      to_cnt_q        <= '0;
      break_pending_q <= 1'b0;
      rx_byte_q       <= 8'd0;
      rx_valid_q      <= 1'b0;
      frame_err_q     <= 1'b0;
      scan_code_q     <= 8'd0;
      blank_q         <= 1'b1;
      key_count_q     <= 8'd0;
    end else begin
      ps2_clk_sync_q  <= {ps2_clk_sync_q[1:0], ps2_clk};
      ps2_data_sync_q <= {ps2_data_sync_q[1:0], ps2_data};
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      to_cnt_q        <= to_cnt_d;
      break_pending_q <= break_pending_d;
      rx_byte_q       <= rx_byte_d;
      rx_valid_q      <= rx_valid_d;
      frame_err_q     <= frame_err_d;
      scan_code_q     <= scan_code_d;
      blank_q         <= blank_d;
      key_count_q     <= key_count_d;
    end
  end

  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign scan_code  = scan_code_q;
  assign blank_flag = blank_q;
  assign key_count  = key_count_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx: bit-banged PS/2 frames, a key-tracking reference
// model, and a scoreboard monitor that compares every rx_valid/frame_err pulse
// and every requested output snapshot.
module tb_ps2_kbd_rx;

  localparam int unsigned TO = 200;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic [7:0] scan_code;
  logic       blank_flag;
  logic [7:0] key_count;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .scan_code (scan_code),
    .blank_flag(blank_flag),
    .key_count (key_count)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] rx;
    logic [7:0] scan;
    logic       blank;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference state: what a keyboard user would see on the display.
  logic [7:0] m_rx, m_scan, m_cnt;
  logic       m_blank, m_bp;

  int n_tests = 0;
  int n_fail  = 0;
  int snap_seq  = 0;
  int snap_done = 0;

  // Monitor: sole owner of the counters and the queue pops.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid || frame_err) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got valid=%b err=%b rx=%h, required no pulse",
                   rx_valid, frame_err, rx_byte);
        end else begin
          mon_e = exp_q.pop_front();
          if ({frame_err, rx_valid, rx_byte, scan_code, blank_flag, key_count} !==
              {mon_e.err, ~mon_e.err, mon_e.rx, mon_e.scan, mon_e.blank, mon_e.cnt}) begin
            n_fail++;
            $display({"FAIL frame_result: got err=%b valid=%b rx=%h scan=%h blank=%b cnt=%0d,",
                      " required err=%b valid=%b rx=%h scan=%h blank=%b cnt=%0d"},
                     frame_err, rx_valid, rx_byte, scan_code, blank_flag, key_count,
                     mon_e.err, ~mon_e.err, mon_e.rx, mon_e.scan, mon_e.blank, mon_e.cnt);
          end
        end
      end
      if (snap_seq != snap_done) begin
        snap_done = snap_seq;
        n_tests++;
        if ({rx_valid, frame_err, rx_byte, scan_code, blank_flag, key_count,
             exp_q.size() == 0} !==
            {2'b00, m_rx, m_scan, m_blank, m_cnt, 1'b1}) begin
          n_fail++;
          $display({"FAIL snapshot_%0d: got valid=%b err=%b rx=%h scan=%h blank=%b cnt=%0d",
                    " pending=%0d, required valid=0 err=0 rx=%h scan=%h blank=%b cnt=%0d",
                    " pending=0"},
                   snap_seq, rx_valid, frame_err, rx_byte, scan_code, blank_flag, key_count,
                   exp_q.size(), m_rx, m_scan, m_blank, m_cnt);
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_rx    = 8'h00;
    m_scan  = 8'h00;
    m_cnt   = 8'h00;
    m_blank = 1'b1;
    m_bp    = 1'b0;
  endtask

  // Key semantics: F0 arms a release, E0 is a bare prefix, the first make
  // after a release latches a new key and counts it, a release of the shown
  // key blanks the display.
  task automatic model_frame(input logic [7:0] b, input logic par_ok, input logic stop);
    logic accept;
    exp_t e;
    accept = stop && (par_ok || !ParEn);
    if (accept) begin
      m_rx = b;
      if (b == 8'hF0) m_bp = 1'b1;
      else if (b == 8'hE0) m_bp = m_bp;
      else if (m_bp) begin
        m_bp = 1'b0;
        if (b == m_scan) m_blank = 1'b1;
      end else if (m_blank) begin
        m_scan  = b;
        m_blank = 1'b0;
        m_cnt   = 8'((int'(m_cnt) + 1) % 256);
      end
    end
    e.err   = !accept;
    e.rx    = m_rx;
    e.scan  = m_scan;
    e.blank = m_blank;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic snap();
    snap_seq++;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    logic par;
    par = (~^b) ^ bad_par;
    model_frame(b, !bad_par, stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
    ps2_data = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    snap();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clrn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    snap();
    clrn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] code;
    logic [7:0] pool [4];
    int r;
    pool[0] = 8'h1C; pool[1] = 8'h32; pool[2] = 8'h21; pool[3] = 8'h23;
    clrn     = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    snap();
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    snap();

    // First press, typematic repeat, release.
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);

    // Bad parity, then bad stop bit.
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);

    // Partial frame abandoned by the timeout, then a clean frame.
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    ps2_data = 1'b1;
    repeat (TO + 10) @(negedge clk);
    snap();
    send_frame(8'h32, 1'b0, 1'b1);

    // Randomized key traffic with occasional line errors.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) code = 8'hF0;
      else if (r < 35) code = 8'hE0;
      else code = pool[$urandom_range(0, 3)];
      send_frame(code, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) != 0));
    end

    // Reset in the middle of a frame discards it.
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    pulse_reset();
    ps2_data = 1'b1;

    // 256 distinct press/release pairs wrap the key counter back to zero.
    for (int n = 0; n < 256; n++) begin
      do code = 8'($urandom_range(0, 255)); while (code == 8'hF0 || code == 8'hE0);
      send_frame(code, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(code, 1'b0, 1'b1);
    end
    send_frame(8'h21, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
